// File: rtl/sseg_pkg.sv
// Shared types and constants for the seven-segment display arbiter.
package sseg_pkg;

  localparam logic [15:0] BLANK_WORD = 16'hFFFF;

  typedef enum logic {
    IDLE,
    OWN
  } arb_state_t;

  function automatic int id_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sseg_display_arbiter_if.sv
// Requester/arbiter bundle for the shared seven-segment display.
interface sseg_display_arbiter_if
  import sseg_pkg::*;
#(
  parameter int NREQ = 4
);
  localparam int IW = id_w(NREQ);

  logic [NREQ-1:0]    req;
  logic [16*NREQ-1:0] req_data;
  logic [NREQ-1:0]    gnt;
  logic               busy;
  logic [IW-1:0]      owner_id;
  logic [15:0]        display_data;

  modport master (
    output req,
    output req_data,
    input  gnt,
    input  busy,
    input  owner_id,
    input  display_data
  );

  modport slave (
    input  req,
    input  req_data,
    output gnt,
    output busy,
    output owner_id,
    output display_data
  );

endinterface

// File: rtl/rr_pick.sv
// Round-robin picker: first unmasked request at or after ptr, wrapping.
module rr_pick
  import sseg_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IW   = id_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  input  logic [NREQ-1:0] mask,
  output logic            found,
  output logic [IW-1:0]   idx
);

  logic [NREQ-1:0] avail;
  logic [IW-1:0]   j;

  assign avail = req & ~mask;

  // Walk farthest-first so the nearest hit to ptr is the last write.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    j     = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      j = IW'((int'(ptr) + i) % NREQ);
      if (avail[j]) begin
        found = 1'b1;
        idx   = j;
      end
    end
  end

endmodule

// File: rtl/sseg_display_arbiter.sv
// Round-robin owner arbitration of the display with a minimum dwell time.
module sseg_display_arbiter
  import sseg_pkg::*;
#(
  parameter  int NREQ  = 4,
  parameter  int DWELL = 2**24,
  localparam int IW    = id_w(NREQ),
  localparam int CW    = $clog2(DWELL + 1)
) (
  input logic                   clk,
  input logic                   clear_n,
  sseg_display_arbiter_if.slave bus
);

  arb_state_t      state;
  logic [IW-1:0]   ptr;
  logic [CW-1:0]   count;
  logic [NREQ-1:0] mask;
  logic            found;
  logic [IW-1:0]   pick;
  logic [IW-1:0]   pick_nxt;
  logic            own_req;
  logic            expired;
  logic            do_grant;
  logic            do_release;
  logic [15:0]     own_data;
  logic [15:0]     pick_data;

  assign own_req   = bus.req[bus.owner_id];
  assign expired   = count >= CW'(DWELL);
  assign own_data  = bus.req_data[16*bus.owner_id +: 16];
  assign pick_data = bus.req_data[16*pick +: 16];
  assign pick_nxt  = (pick == IW'(NREQ - 1)) ? '0 : pick + IW'(1);

  // The current owner is never its own successor.
  assign mask = (state == OWN) ? (NREQ'(1) << bus.owner_id) : '0;

  rr_pick #(
    .NREQ (NREQ)
  ) u_pick (
    .req   (bus.req),
    .ptr   (ptr),
    .mask  (mask),
    .found (found),
    .idx   (pick)
  );

  // A dropped owner releases at once; dwell only gates preemption.
  always_comb begin
    do_grant   = 1'b0;
    do_release = 1'b0;
    unique case (state)
      IDLE: do_grant = found;
      OWN: begin
        do_grant   = found && (!own_req || expired);
        do_release = !own_req && !found;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state            <= IDLE;
      ptr              <= '0;
      count            <= '0;
      bus.gnt          <= '0;
      bus.busy         <= 1'b0;
      bus.owner_id     <= '0;
      bus.display_data <= BLANK_WORD;
    end else if (do_grant) begin
      state            <= OWN;
      ptr              <= pick_nxt;
      count            <= '0;
      bus.gnt          <= NREQ'(1) << pick;
      bus.busy         <= 1'b1;
      bus.owner_id     <= pick;
      bus.display_data <= pick_data;
    end else if (do_release) begin
      state            <= IDLE;
      bus.gnt          <= '0;
      bus.busy         <= 1'b0;
      bus.display_data <= BLANK_WORD;
    end else if (state == OWN) begin
      bus.display_data <= own_data;
      if (!expired) begin
        count <= count + CW'(1);
      end
    end
  end

endmodule
